// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b receive PCS descrambler and block-lock logic.
package pcs_pkg;

  localparam int unsigned SCR_LEN = 58;
  localparam int unsigned SCR_TAP = 39;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    HUNT,
    LOCKED,
    SLIP_HOLD
  } lock_state_t;

  function automatic logic sh_is_good(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_block_lock_fsm.sv
// 66b sync-header block-lock state machine: hunts for lock, monitors bad headers while locked,
// and issues single-cycle gearbox slip requests followed by a fixed hold-off.
module pcs_block_lock_fsm
  import pcs_pkg::*;
#(
  parameter int unsigned SH_GOOD_LOCK = 64,
  parameter int unsigned SH_WIN       = 64,
  parameter int unsigned SH_BAD_MAX   = 16,
  parameter int unsigned SLIP_WAIT    = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic hdr_valid,
  input  logic hdr_good,
  output logic block_lock,
  output logic slip
);

  localparam int unsigned MAX_CNT = (SH_GOOD_LOCK > SH_WIN) ? SH_GOOD_LOCK : SH_WIN;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

  localparam logic [CNT_W-1:0]  GOOD_LIM  = CNT_W'(SH_GOOD_LOCK);
  localparam logic [CNT_W-1:0]  WIN_LIM   = CNT_W'(SH_WIN);
  localparam logic [CNT_W-1:0]  BAD_LIM   = CNT_W'(SH_BAD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

  lock_state_t       state;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  bad_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic [CNT_W-1:0]  good_inc;
  logic [CNT_W-1:0]  win_inc;
  logic [CNT_W-1:0]  bad_inc;

  always_comb begin
    good_inc = good_cnt + CNT_W'(1);
    win_inc  = win_cnt + CNT_W'(1);
    bad_inc  = bad_cnt + CNT_W'(!hdr_good);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= HUNT;
      good_cnt   <= '0;
      win_cnt    <= '0;
      bad_cnt    <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
    end else begin
      slip <= 1'b0;
      case (state)
        HUNT: begin
          if (hdr_valid) begin
            if (!hdr_good) begin
              slip     <= 1'b1;
              state    <= SLIP_HOLD;
              good_cnt <= '0;
              wait_cnt <= '0;
            end else if (good_inc == GOOD_LIM) begin
              state      <= LOCKED;
              block_lock <= 1'b1;
              good_cnt   <= '0;
              win_cnt    <= '0;
              bad_cnt    <= '0;
            end else begin
              good_cnt <= good_inc;
            end
          end
        end

        // Hold-off counts raw cycles so the gearbox slip settles before headers are trusted again.
        SLIP_HOLD: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= HUNT;
            wait_cnt <= '0;
            good_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        LOCKED: begin
          if (hdr_valid) begin
            if (bad_inc == BAD_LIM) begin
              block_lock <= 1'b0;
              slip       <= 1'b1;
              state      <= SLIP_HOLD;
              win_cnt    <= '0;
              bad_cnt    <= '0;
              wait_cnt   <= '0;
            end else if (win_inc == WIN_LIM) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_inc;
              bad_cnt <= bad_inc;
            end
          end
        end

        default: begin
          state      <= HUNT;
          block_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pcs_descrambler_lock.sv
// Self-synchronous x^58+x^39+1 descrambler with registered outputs and 66b block lock.
// Optional DESCRAMBLER_BYPASS_EN adds a bypass input passing payload through unmodified.
module pcs_descrambler_lock
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned SH_GOOD_LOCK = 64,
  parameter int unsigned SH_WIN       = 64,
  parameter int unsigned SH_BAD_MAX   = 16,
  parameter int unsigned SLIP_WAIT    = 4
) (
  input  logic              CLK,
  input  logic              reset,
`ifdef DESCRAMBLER_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sh_valid,
  input  logic [1:0]        in_sh,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sh,
  output logic              out_sh_valid,
  output logic              block_lock,
  output logic              slip
);

  logic [SCR_LEN-1:0]        hist;
  logic [DATA_W+SCR_LEN-1:0] ext;
  logic [DATA_W-1:0]         descr;
  logic [DATA_W-1:0]         data_next;

  // ext[SCR_LEN+i] is the current bit; lower indices reach back 39 and 58 bit times.
  always_comb begin
    ext   = {in_data, hist};
    descr = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      descr[i] = ext[SCR_LEN + i] ^ ext[SCR_LEN - SCR_TAP + i] ^ ext[i];
    end
  end

`ifdef DESCRAMBLER_BYPASS_EN
  assign data_next = bypass ? in_data : descr;
`else
  assign data_next = descr;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      hist         <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sh       <= '0;
      out_sh_valid <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      out_sh_valid <= in_valid & in_sh_valid;
      if (in_valid) begin
        hist     <= ext[DATA_W +: SCR_LEN];
        out_data <= data_next;
        out_sh   <= in_sh;
      end
    end
  end

  pcs_block_lock_fsm #(
    .SH_GOOD_LOCK(SH_GOOD_LOCK),
    .SH_WIN      (SH_WIN),
    .SH_BAD_MAX  (SH_BAD_MAX),
    .SLIP_WAIT   (SLIP_WAIT)
  ) u_lock (
    .CLK       (CLK),
    .reset     (reset),
    .hdr_valid (in_valid & in_sh_valid),
    .hdr_good  (sh_is_good(in_sh)),
    .block_lock(block_lock),
    .slip      (slip)
  );

endmodule

// File: tb/tb_pcs_descrambler_lock.sv
// Scoreboard bench for pcs_descrambler_lock: directed beats push expectations, a monitor checks outputs.
`timescale 1ns/1ps
module tb_pcs_descrambler_lock;

  typedef struct {
    logic [63:0] data;
    bit          chk_data;
    logic [1:0]  sh;
    bit          shv;
    bit          lock;
    bit          slip;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_sh_valid;
  logic [1:0]  in_sh;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_sh;
  logic        out_sh_valid;
  logic        block_lock;
  logic        slip;
`ifdef DESCRAMBLER_BYPASS_EN
  logic        bypass;
`endif

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rst_req = 1'b0;
  bit          done    = 1'b0;
  logic [57:0] st;

  always #5 CLK = ~CLK;

  pcs_descrambler_lock #(
    .DATA_W      (64),
    .SH_GOOD_LOCK(64),
    .SH_WIN      (64),
    .SH_BAD_MAX  (16),
    .SLIP_WAIT   (4)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
`ifdef DESCRAMBLER_BYPASS_EN
    .bypass      (bypass),
`endif
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sh_valid (in_sh_valid),
    .in_sh       (in_sh),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sh      (out_sh),
    .out_sh_valid(out_sh_valid),
    .block_lock  (block_lock),
    .slip        (slip)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset checks on request, scoreboard pops on every valid output.
  initial begin
    bit   rst_seen;
    exp_t e;
    rst_seen = 1'b0;
    forever begin
      @(negedge CLK);
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sh", 64'(out_sh), 64'd0);
        chk("rst_out_sh_valid", 64'(out_sh_valid), 64'd0);
        chk("rst_block_lock", 64'(block_lock), 64'd0);
        chk("rst_slip", 64'(slip), 64'd0);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          if (e.chk_data) chk("out_data", out_data, e.data);
          chk("out_sh", 64'(out_sh), 64'(e.sh));
          chk("out_sh_valid", 64'(out_sh_valid), 64'(e.shv));
          chk("block_lock", 64'(block_lock), 64'(e.lock));
          chk("slip", 64'(slip), 64'(e.slip));
        end
      end
      if (done) begin
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [63:0] d, input bit shv, input logic [1:0] sh,
                      input bit lock, input bit slp, input bit chkd, input logic [63:0] expd);
    exp_t e;
    in_valid    = 1'b1;
    in_data     = d;
    in_sh_valid = shv;
    in_sh       = sh;
    e.data = expd; e.chk_data = chkd; e.sh = sh; e.shv = shv; e.lock = lock; e.slip = slp;
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic gap();
    in_valid    = 1'b0;
    in_sh_valid = 1'b1;
    in_sh       = 2'b11;
    in_data     = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset(input bit iv);
    reset    = 1'b1;
    in_valid = iv;
    @(posedge CLK); #1;
    rst_req = ~rst_req;
    @(posedge CLK); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Bit-serial reference scrambler: s[n] = d[n] ^ s[n-39] ^ s[n-58], st[k] = s[n-1-k].
  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b    = d[i] ^ st[38] ^ st[57];
      s[i] = b;
      st   = {st[56:0], b};
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] s;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sh_valid = 1'b0; in_sh = 2'b00;
`ifdef DESCRAMBLER_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    apply_reset(1'b0);

    // Single set bit lands on the current, 39-back and 58-back taps.
    beat(64'h1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 64'h0400_0080_0000_0001);
    beat(64'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 64'h0);

    apply_reset(1'b0);
    st = 58'h2AB_CDEF_0123_4567;
    for (int n = 0; n < 200; n++) begin
      d = {$urandom, $urandom};
      scramble(d, s);
      beat(s, 1'b0, 2'b10, 1'b0, 1'b0, n > 0, d);
    end

    // Lock after 64 good headers; invalid gaps carrying bad headers must not count.
    apply_reset(1'b0);
    for (int k = 1; k <= 64; k++) begin
      beat(64'h0, 1'b1, (k % 2) ? 2'b01 : 2'b10, k == 64, 1'b0, 1'b1, 64'h0);
      if (k % 16 == 5) gap();
    end

    // Window 1: 15 bad at the end; window 2: 15 bad at the start; stays locked.
    for (int h = 1; h <= 64; h++)
      beat(64'h0, 1'b1, (h >= 50) ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'b1, 64'h0);
    for (int h = 1; h <= 64; h++)
      beat(64'h0, 1'b1, (h <= 15) ? 2'b00 : 2'b01, 1'b1, 1'b0, 1'b1, 64'h0);
    for (int h = 1; h <= 16; h++)
      beat(64'h0, 1'b1, 2'b11, h != 16, h == 16, 1'b1, 64'h0);

    // HUNT: bad header on beat 10, next 4 beats ignored, then a full fresh count.
    apply_reset(1'b0);
    for (int b = 1; b <= 14; b++)
      beat(64'h0, 1'b1, (b >= 10) ? 2'b11 : 2'b01, 1'b0, b == 10, 1'b1, 64'h0);
    for (int b = 15; b <= 78; b++)
      beat(64'h0, 1'b1, 2'b01, b == 78, 1'b0, 1'b1, 64'h0);

    // Reset while locked and streaming; afterwards hist must be clear again.
    for (int n = 0; n < 3; n++)
      beat({$urandom, $urandom}, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
    in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0; in_sh_valid = 1'b1; in_sh = 2'b01;
    apply_reset(1'b1);
    beat(64'h1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 64'h0400_0080_0000_0001);

`ifdef DESCRAMBLER_BYPASS_EN
    bypass = 1'b1;
    beat(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    beat(64'h0123_4567_89AB_CDEF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
    bypass = 1'b0;
`endif

    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    done = 1'b1;
  end

endmodule

// File: doc/pcs_descrambler_lock.md
Name: pcs_descrambler_lock

Overview:
Parametrised self-synchronous descrambler for the x^58+x^39+1 polynomial, with an integrated 66b sync-header block-lock state machine.
- Sits between the RX gearbox and the 64b/66b decoder.
- Descrambles a DATA_W-bit payload per valid beat, with 1-cycle registered latency.
- Checks 2-bit sync headers and drives a slip request back to the gearbox until block lock is achieved.
- Successor of the fixed-width, unregistered, lock-less descrambler.

Parameters:
DATA_W, 64, payload bits per beat (any value >= 1; lock logic only meaningful with 64).
SH_GOOD_LOCK, 64, consecutive valid headers required to declare lock.
SH_WIN, 64, headers per bad-header monitoring window while locked.
SH_BAD_MAX, 16, invalid headers within one window that cause loss of lock.
SLIP_WAIT, 4, cycles of idle after a slip pulse before header checking resumes.

Ports:
CLK  input  1  clock; all logic on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  in_data beat valid
in_data  input  DATA_W  scrambled payload, bit 0 first-transmitted
in_sh_valid  input  1  in_sh valid this beat (qualified by in_valid)
in_sh  input  2  sync header
out_valid  output  1  registered in_valid
out_data  output  DATA_W  descrambled payload
out_sh  output  2  registered in_sh
out_sh_valid  output  1  registered in_valid & in_sh_valid
block_lock  output  1  high in LOCKED
slip  output  1  one-cycle pulse requesting a 1-bit gearbox slip

Behaviour:
- Reset: sync active-high on CLK. All outputs 0, hist (58 bits) = 0, FSM = HUNT, all counters = 0. Reset wins over every other event.
- Descrambling:
  - ext = {in_data, hist}, width DATA_W+58.
  - out_data[i] = ext[58+i] ^ ext[19+i] ^ ext[i].
  - hist_next = ext[DATA_W+57 : DATA_W], i.e. the newest 58 scrambled bits.
  - hist updates only when in_valid=1; otherwise hist, out_data and out_sh hold, and out_valid=0.
  - Descrambling runs regardless of lock state; it is self-synchronising and correct 58 bits after a clean stream starts.
- Latency: outputs registered, 1 cycle after the input beat.
- Header check: evaluated only when in_valid & in_sh_valid. Good = 2'b01 or 2'b10; bad = 2'b00 or 2'b11.
- FSM HUNT:
  - Good header: good_cnt++.
  - good_cnt reaching SH_GOOD_LOCK: go to LOCKED, clear counters.
  - Bad header: slip=1 for one cycle, go to SLIP_HOLD, clear counters.
- FSM SLIP_HOLD:
  - Wait counter counts SLIP_WAIT cycles, counting every cycle regardless of in_valid.
  - Headers are ignored.
  - Then return to HUNT.
- FSM LOCKED:
  - block_lock=1.
  - Each checked header increments win_cnt; each bad header increments bad_cnt.
  - bad_cnt reaching SH_BAD_MAX: block_lock=0, slip pulse, go to SLIP_HOLD, clear counters. This takes priority over window end on the same header.
  - win_cnt reaching SH_WIN with bad_cnt < SH_BAD_MAX: clear both counters, stay LOCKED.
- block_lock and slip are registered and change in the cycle after the deciding header.
- Counter width: clog2(max(SH_GOOD_LOCK, SH_WIN)+1); saturation is never reached.

Optional Feature:
DESCRAMBLER_BYPASS_EN
- Defined: adds input port bypass (1 bit). When bypass=1, out_data = registered in_data unmodified. hist keeps updating so leaving bypass needs no resync. Header/lock logic is unaffected.
- Undefined: no port; data is always descrambled.

Decomposition:
- Shared package pcs_pkg:
  - SCR_LEN=58, SCR_TAP=39.
  - SH_DATA=2'b01, SH_CTRL=2'b10.
  - lock_state_t enum {HUNT, LOCKED, SLIP_HOLD}.
- Sub-module pcs_block_lock_fsm contains the FSM, counters, slip and block_lock. The top holds the descrambler datapath and output registers.

Test Plan:
- Reset, then in_valid=1, in_data=64'h1 -> next cycle out_data=64'h0400_0080_0000_0001, out_valid=1. Following beat in_data=0 -> out_data=0.
- Scramble a random 200-beat stream with x^58+x^39+1 from a nonzero seed and feed it; from beat 2 onward -> out_data equals the original payload. Beat 1 may differ.
- 64 beats of in_sh=2'b01 with in_sh_valid=1 -> block_lock rises 1 cycle after the 64th header. in_valid low gaps in between -> lock is only delayed, never lost.
- In HUNT, in_sh=2'b11 on beat 10 -> slip pulses exactly one cycle. Headers during the next 4 cycles are ignored, then good_cnt restarts from 0.
- Locked: 15 bad headers in a 64-header window -> stays locked, counters clear at window end. 16 bad headers -> block_lock=0 plus a slip pulse 1 cycle after the 16th.
- Assert reset mid-LOCKED while in_valid=1 -> next cycle all outputs 0, block_lock=0, hist=0. With DESCRAMBLER_BYPASS_EN and bypass=1, out_data equals in_data delayed 1 cycle.
